// File: rtl/uart_hex_printer.sv
// uart_hex_printer: prints (reg, data) requests as "R<idx>:<hex>" LF CR through a UART TX FIFO; passes UART RX bytes through.
// Define UART_HEX_PRINTER_ZSUP_EN to suppress leading zero data digits (the last digit always prints).

module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic [W-1:0] i_din,
  input  logic         i_rd,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (i_wr && !o_full) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  // Registered read: o_dout holds the popped word from the cycle after i_rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      o_dout <= '0;
    end else begin
      if (i_wr && !o_full) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_rd && !o_empty) begin
        o_dout <= r_mem[r_rptr[AW-1:0]];
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end
endmodule

module uart_core #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_tx,
  input  logic       i_transmit,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_active,
  output logic       o_received,
  output logic [7:0] o_rx_byte
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [9:0]    r_tx_sr;
  logic [3:0]    r_tx_bits, r_rx_bit;
  logic [CW-1:0] r_tx_clk, r_rx_clk;
  logic          r_tx_active, r_rx_meta, r_rx_sync, r_rx_busy;
  logic [7:0]    r_rx_sr;

  assign o_tx        = r_tx_active ? r_tx_sr[0] : 1'b1;
  assign o_tx_active = r_tx_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_active <= 1'b0;
      r_tx_sr     <= '1;
      r_tx_bits   <= '0;
      r_tx_clk    <= '0;
    end else if (!r_tx_active) begin
      if (i_transmit) begin
        r_tx_sr     <= {1'b1, i_tx_byte, 1'b0};
        r_tx_active <= 1'b1;
        r_tx_clk    <= CW'(CLKS_PER_BIT-1);
        r_tx_bits   <= '0;
      end
    end else if (r_tx_clk != '0) begin
      r_tx_clk <= r_tx_clk - CW'(1);
    end else begin
      r_tx_clk  <= CW'(CLKS_PER_BIT-1);
      r_tx_sr   <= {1'b1, r_tx_sr[9:1]};
      r_tx_bits <= r_tx_bits + 4'd1;
      if (r_tx_bits == 4'd9) r_tx_active <= 1'b0;
    end
  end

  // RX samples mid-bit; a start bit that is high again at its centre is treated as a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_clk   <= '0;
      r_rx_bit   <= '0;
      r_rx_sr    <= '0;
      o_rx_byte  <= '0;
      o_received <= 1'b0;
    end else begin
      r_rx_meta  <= i_rx;
      r_rx_sync  <= r_rx_meta;
      o_received <= 1'b0;
      if (!r_rx_busy) begin
        if (!r_rx_sync) begin
          r_rx_busy <= 1'b1;
          r_rx_clk  <= CW'(CLKS_PER_BIT/2 - 1);
          r_rx_bit  <= '0;
        end
      end else if (r_rx_clk != '0) begin
        r_rx_clk <= r_rx_clk - CW'(1);
      end else begin
        r_rx_clk <= CW'(CLKS_PER_BIT-1);
        r_rx_bit <= r_rx_bit + 4'd1;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_sync) r_rx_busy <= 1'b0;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_rx_sync) begin
            o_received <= 1'b1;
            o_rx_byte  <= r_rx_sr;
          end
        end else begin
          r_rx_sr <= {r_rx_sync, r_rx_sr[7:1]};
        end
      end
    end
  end
endmodule

module uart_hex_printer #(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [REG_W-1:0]  i_req_reg,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_tx,
  input  logic              i_rx,
  output logic [7:0]        o_rx_data,
  output logic              o_rx_valid
);
  localparam int INIB  = (REG_W + 3) / 4;
  localparam int DNIB  = (DATA_W + 3) / 4;
  localparam int MAXN  = (INIB > DNIB) ? INIB : DNIB;
  localparam int CNT_W = $clog2(MAXN) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRINT_R, S_PRINT_IDX, S_PRINT_COLON, S_PRINT_DATA, S_PRINT_LF, S_PRINT_CR
  } state_t;

  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic [4*INIB-1:0] r_idx_sr, w_idx_nx;
  logic [4*DNIB-1:0] r_data_sr, w_data_nx;
  logic              r_rd_z, w_fifo_wr, w_fifo_rd, w_fifo_full, w_fifo_empty, w_tx_active, w_skip;
  logic [7:0]        w_fifo_din, w_fifo_dout;
  logic [3:0]        w_idx_nib, w_data_nib;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign o_req_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign w_idx_nib   = r_idx_sr[4*INIB-1 -: 4];
  assign w_data_nib  = r_data_sr[4*DNIB-1 -: 4];

`ifdef UART_HEX_PRINTER_ZSUP_EN
  logic r_lead, w_lead_nx;
  assign w_skip = r_lead && (w_data_nib == 4'h0) && (r_cnt != CNT_W'(DNIB-1));
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx_sr  <= '0;
      r_data_sr <= '0;
      r_rd_z    <= 1'b0;
`ifdef UART_HEX_PRINTER_ZSUP_EN
      r_lead    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_idx_sr  <= w_idx_nx;
      r_data_sr <= w_data_nx;
      r_rd_z    <= w_fifo_rd;
`ifdef UART_HEX_PRINTER_ZSUP_EN
      r_lead    <= w_lead_nx;
`endif
    end
  end

  // Every printing state writes one byte and advances only when the FIFO takes it.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx_sr;
    w_data_nx  = r_data_sr;
    w_fifo_wr  = 1'b0;
    w_fifo_din = 8'h00;
    o_done     = 1'b0;
`ifdef UART_HEX_PRINTER_ZSUP_EN
    w_lead_nx  = r_lead;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_nx = S_PRINT_R;
          w_cnt_nx   = '0;
          w_idx_nx   = (4*INIB)'(i_req_reg);
          w_data_nx  = (4*DNIB)'(i_req_data);
`ifdef UART_HEX_PRINTER_ZSUP_EN
          w_lead_nx  = 1'b1;
`endif
        end
      end
      S_PRINT_R: begin
        w_fifo_din = 8'h52;
        w_fifo_wr  = !w_fifo_full;
        if (!w_fifo_full) w_state_nx = S_PRINT_IDX;
      end
      S_PRINT_IDX: begin
        w_fifo_din = hex(w_idx_nib);
        w_fifo_wr  = !w_fifo_full;
        if (!w_fifo_full) begin
          w_idx_nx = r_idx_sr << 4;
          w_cnt_nx = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(INIB-1)) begin
            w_state_nx = S_PRINT_COLON;
            w_cnt_nx   = '0;
          end
        end
      end
      S_PRINT_COLON: begin
        w_fifo_din = 8'h3A;
        w_fifo_wr  = !w_fifo_full;
        if (!w_fifo_full) w_state_nx = S_PRINT_DATA;
      end
      S_PRINT_DATA: begin
        w_fifo_din = hex(w_data_nib);
        w_fifo_wr  = !w_fifo_full && !w_skip;
        if (!w_fifo_full || w_skip) begin
          w_data_nx = r_data_sr << 4;
          w_cnt_nx  = r_cnt + CNT_W'(1);
`ifdef UART_HEX_PRINTER_ZSUP_EN
          w_lead_nx = w_skip;
`endif
          if (r_cnt == CNT_W'(DNIB-1)) begin
            w_state_nx = S_PRINT_LF;
            w_cnt_nx   = '0;
          end
        end
      end
      S_PRINT_LF: begin
        w_fifo_din = 8'h0A;
        w_fifo_wr  = !w_fifo_full;
        if (!w_fifo_full) w_state_nx = S_PRINT_CR;
      end
      S_PRINT_CR: begin
        w_fifo_din = 8'h0D;
        w_fifo_wr  = !w_fifo_full;
        o_done     = !w_fifo_full;
        if (!w_fifo_full) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // r_rd_z blocks a second pop in the cycle before the UART raises tx_active.
  assign w_fifo_rd = !w_fifo_empty && !w_tx_active && !r_rd_z;

  uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_wr(w_fifo_wr), .i_din(w_fifo_din), .i_rd(w_fifo_rd),
    .o_dout(w_fifo_dout), .o_full(w_fifo_full), .o_empty(w_fifo_empty)
  );

  uart_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk(clk), .rst(rst), .i_rx(i_rx), .o_tx(o_tx), .i_transmit(r_rd_z),
    .i_tx_byte(w_fifo_dout), .o_tx_active(w_tx_active), .o_received(o_rx_valid),
    .o_rx_byte(o_rx_data)
  );
endmodule

// File: tb/tb_uart_hex_printer.sv
// Bench for uart_hex_printer: two instances (32/2 and 10/5 widths), o_tx decoded and checked against a queue of expected bytes.
module tb_uart_hex_printer;
  localparam int CPB = 8;
`ifdef UART_HEX_PRINTER_ZSUP_EN
  localparam bit ZSUP = 1'b1;
`else
  localparam bit ZSUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v1, rdy1, busy1, done1, tx1, rx1, rxv1;
  logic [1:0]  r1;
  logic [31:0] d1;
  logic [7:0]  rxd1;
  logic        v2, rdy2, busy2, done2, tx2, rx2, rxv2;
  logic [4:0]  r2;
  logic [9:0]  d2;
  logic [7:0]  rxd2;

  uart_hex_printer #(.DATA_W(32), .REG_W(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .i_req_valid(v1), .o_req_ready(rdy1), .i_req_reg(r1),
    .i_req_data(d1), .o_busy(busy1), .o_done(done1), .o_tx(tx1), .i_rx(rx1),
    .o_rx_data(rxd1), .o_rx_valid(rxv1)
  );

  uart_hex_printer #(.DATA_W(10), .REG_W(5), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) u_dut2 (
    .clk(clk), .rst(rst), .i_req_valid(v2), .o_req_ready(rdy2), .i_req_reg(r2),
    .i_req_data(d2), .o_busy(busy2), .o_done(done2), .o_tx(tx2), .i_rx(rx2),
    .o_rx_data(rxd2), .o_rx_valid(rxv2)
  );

  int         n_cmp = 0, n_err = 0;
  logic [7:0] q0[$], q1[$];
  bit         dec_en = 1'b0, mon_en0 = 1'b1, full_seen = 1'b0;
  int         done_cnt1 = 0, done_cnt2 = 0, rxv_cnt = 0;
  logic [7:0] rx_last = 8'h00;
  string      HX = "0123456789ABCDEF";

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic push_b(input int w, input logic [7:0] b);
    if (w == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic push_line(input int w, input logic [31:0] r, input int inib,
                           input logic [63:0] d, input int dnib);
    bit lead = ZSUP;
    int n;
    push_b(w, 8'h52);
    for (int i = inib - 1; i >= 0; i--) push_b(w, HX[int'((r >> (4*i)) & 32'hF)]);
    push_b(w, 8'h3A);
    for (int i = dnib - 1; i >= 0; i--) begin
      n = int'((d >> (4*i)) & 64'hF);
      if (!(lead && n == 0 && i > 0)) begin
        lead = 1'b0;
        push_b(w, HX[n]);
      end
    end
    push_b(w, 8'h0A);
    push_b(w, 8'h0D);
  endtask

  task automatic uart_get(input int w, output logic [7:0] b);
    do @(negedge clk); while (((w == 0) ? tx1 : tx2) !== 1'b0);
    repeat (CPB/2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = (w == 0) ? tx1 : tx2;
    end
    repeat (CPB) @(negedge clk);
  endtask

  task automatic req1(input logic [1:0] r, input logic [31:0] d, input bit exp);
    int t = 0;
    if (exp) push_line(0, {30'd0, r}, 1, {32'd0, d}, 8);
    @(negedge clk);
    v1 = 1'b1; r1 = r; d1 = d;
    while (!rdy1 && t < 20000) begin @(negedge clk); t++; end
    if (!rdy1) begin
      n_cmp++; n_err++;
      $display("FAIL req1_accept: ready still %0b after %0d cycles, expected 1", rdy1, t);
      v1 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    v1 = 1'b0; r1 = 2'($urandom); d1 = $urandom;
  endtask

  task automatic req2(input logic [4:0] r, input logic [9:0] d);
    int t = 0;
    push_line(1, {27'd0, r}, 2, {54'd0, d}, 3);
    @(negedge clk);
    v2 = 1'b1; r2 = r; d2 = d;
    while (!rdy2 && t < 20000) begin @(negedge clk); t++; end
    if (!rdy2) begin
      n_cmp++; n_err++;
      $display("FAIL req2_accept: ready still %0b after %0d cycles, expected 1", rdy2, t);
      v2 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    v2 = 1'b0; r2 = 5'($urandom); d2 = 10'($urandom);
  endtask

  task automatic wait_drain(input int w);
    int t = 0;
    while (((w == 0) ? q0.size() : q1.size()) != 0 && t < 30000) begin @(negedge clk); t++; end
    chk((w == 0) ? "drain_dut1" : "drain_dut2", (w == 0) ? q0.size() : q1.size(), 0);
    repeat (2*CPB) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done1) done_cnt1++;
    if (done2) done_cnt2++;
    if (rxv1) begin rxv_cnt++; rx_last = rxd1; end
    if (u_dut1.w_fifo_full) full_seen = 1'b1;
  end

  initial begin
    logic [7:0] b;
    wait (dec_en);
    forever begin
      uart_get(0, b);
      if (mon_en0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx1_byte: got %0h, no byte expected", b);
        end else chk("tx1_byte", b, q0.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] b;
    wait (dec_en);
    forever begin
      uart_get(1, b);
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL tx2_byte: got %0h, no byte expected", b);
      end else chk("tx2_byte", b, q1.pop_front());
    end
  end

  initial begin
    int lat, t, rx_base;
    logic [7:0] rxb;
    v1 = 0; r1 = 0; d1 = 0; rx1 = 1;
    v2 = 0; r2 = 0; d2 = 0; rx2 = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", rdy1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_tx", tx1, 1);
    chk("rst_ready2", rdy2, 1);
    dec_en = 1'b1;

    // Basic line and accept-to-done latency with an empty FIFO.
    req1(2'd2, 32'hDEADBEEF, 1'b1);
    lat = 0;
    @(negedge clk);
    while (!done1 && lat < 100) begin @(negedge clk); lat++; end
    chk("done_latency", lat, 12);
    wait_drain(0);
    chk("done_cnt_line1", done_cnt1, 1);

    // Odd widths: 2 index digits, 3 data digits.
    req2(5'h13, 10'h3FF);
    req2(5'h13, 10'h005);
    req2(5'h13, 10'h000);
    wait_drain(1);
    chk("done_cnt_dut2", done_cnt2, 3);

    // Three lines back-to-back overrun the 16-entry FIFO.
    req1(2'd0, 32'h01234567, 1'b1);
    req1(2'd1, 32'h89ABCDEF, 1'b1);
    req1(2'd3, 32'h0000ABCD, 1'b1);
    wait_drain(0);
    chk("fifo_full_seen", full_seen, 1);
    chk("done_cnt_backpressure", done_cnt1, 4);

    // New request held valid during a line; inputs change right after accept.
    push_line(0, 32'd1, 1, 64'h12345678, 8);
    push_line(0, 32'd3, 1, 64'hCAFEF00D, 8);
    @(negedge clk);
    v1 = 1'b1; r1 = 2'd1; d1 = 32'h12345678;
    @(posedge clk); #1;
    r1 = 2'd3; d1 = 32'hCAFEF00D;
    repeat (4) begin
      @(negedge clk);
      chk("busy_ready", rdy1, 0);
      chk("busy_busy", busy1, 1);
    end
    t = 0;
    while (!rdy1 && t < 20000) begin @(negedge clk); t++; end
    chk("busy_reaccept", rdy1, 1);
    @(posedge clk); #1;
    v1 = 1'b0; d1 = $urandom;
    wait_drain(0);
    chk("done_cnt_busy", done_cnt1, 6);

    // Reset after "R2:DE" is in the FIFO.
    mon_en0 = 1'b0;
    req1(2'd2, 32'hDEADBEEF, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy1, 0);
    chk("midrst_ready", rdy1, 1);
    chk("midrst_fifo_empty", u_dut1.w_fifo_empty, 1);
    chk("midrst_tx", tx1, 1);
    chk("midrst_done_cnt", done_cnt1, 6);
    repeat (12*CPB) @(negedge clk);
    mon_en0 = 1'b1;
    req1(2'd1, 32'h0000ABCD, 1'b1);
    wait_drain(0);
    chk("done_cnt_after_rst", done_cnt1, 7);

    // RX: one 0x55 frame.
    rx_base = rxv_cnt;
    rxb = 8'h55;
    @(negedge clk);
    rx1 = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx1 = rxb[i];
      repeat (CPB) @(negedge clk);
    end
    rx1 = 1'b1;
    repeat (3*CPB) @(negedge clk);
    chk("rx_pulses", rxv_cnt - rx_base, 1);
    chk("rx_data", rx_last, 8'h55);

    chk("q0_leftover", q0.size(), 0);
    chk("q1_leftover", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
